alu_rr_sequencer: RTL
=====================

// Module: alu_rr_sequencer
// PURPOSE
//  Shares one 32-bit combinational 8-op ALU (op 000 AND,001 OR,010 XOR,011 NOR,100 ADD,
//  101 SUB,110 SLTU,111 SRL) between two requesters. Round-robin arbitration, operand capture,
//  driving the ALU for ALU_LAT cycles, result/flag capture, and return to the winner over
//  valid/ready. Sits between the requester front-ends and the shared ALU instance.
// PARAMETERS
//  ALU_LAT  1   cycles operands are held on the ALU before F/ZF/OF are sampled; legal 1..15
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst          in   1   asynchronous reset, active-high
//  reqN_valid   in   1   (N=0,1) requester N has an op pending; must hold until accepted
//  reqN_ready   out  1   (N=0,1) request accepted this cycle when reqN_valid&reqN_ready
//  reqN_op      in   3   (N=0,1) ALU opcode, encoding as in PURPOSE
//  reqN_a       in   32  (N=0,1) operand A
//  reqN_b       in   32  (N=0,1) operand B
//  rspN_valid   out  1   (N=0,1) result for requester N is available
//  rspN_ready   in   1   (N=0,1) requester N takes the result
//  rsp_f        out  32  captured ALU result, shared by both response channels
//  rsp_zf       out  1   captured zero flag
//  rsp_of       out  1   captured signed-overflow flag (ADD/SUB only, 0 otherwise)
//  alu_op       out  3   opcode driven to the shared ALU (registered)
//  alu_a        out  32  operand A to the ALU (registered)
//  alu_b        out  32  operand B to the ALU (registered)
//  alu_f        in   32  ALU result
//  alu_zf       in   1   ALU zero flag
//  alu_of       in   1   ALU overflow flag
//  busy         out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state IDLE; reqN_ready=0, rspN_valid=0, rsp_f=0, rsp_zf=0, rsp_of=0, alu_op=0,
//   alu_a=0, alu_b=0, busy=0, lat counter=0, last_grant=1 (requester 0 wins first).
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: winner = only valid requester; if both valid, the one != last_grant. reqN_ready is
//   combinational, high only for the winner and only in IDLE. On the accept edge:
//   alu_op/a/b <= winner's op/a/b, last_grant <= winner, counter <= ALU_LAT-1, -> EXEC.
//   No valid: stay IDLE; ALU operand registers hold their last values.
//  EXEC: ALU inputs stable. Counter decrements each cycle. In the cycle counter==0:
//   rsp_f<=alu_f, rsp_zf<=alu_zf, rsp_of<=alu_of, -> RESP.
//  RESP: rspN_valid=1 for the granted N only; rsp_* stable. Leave to IDLE on the edge where
//   rspN_ready=1. rspN_ready may already be high on entry (single RESP cycle).
//   Loser's valid is ignored until IDLE.
//  Timing: accept edge T; EXEC occupies T+1..T+ALU_LAT; rspN_valid high from cycle
//   T+ALU_LAT+1. Minimum issue interval ALU_LAT+2 cycles; one op in flight; no
//   accept/respond overlap.
//  Fairness: with both valid continuously, grants alternate 0,1,0,1...
//  Backpressure: rspN_ready low holds RESP indefinitely; reqN_ready stays 0 for both.
//  rst asserted mid-transaction: immediate return to reset values; in-flight op dropped,
//   no response issued.
//  Width: no arithmetic on operands; flags taken from the ALU unmodified.
//   Counter 4 bits; ALU_LAT out of 1..15 is a configuration error.
// TESTING
//  r0 op=100 A=7FFFFFFF B=7FFFFFFF, ALU_LAT=1 -> rsp0_valid 2 cycles after accept,
//   rsp_f=FFFFFFFE, zf=0, of=1.
//  r1 op=101 A=80000000 B=80000000 -> rsp1_valid only, rsp_f=00000000, zf=1, of=0.
//  Both valid from reset, r0 op=110 A=3 B=607, r1 op=000 A=0 B=FFFFFFFF ->
//   r0 first (rsp_f=1), then r1 (rsp_f=0, zf=1); repeat -> strict alternation.
//  rsp0_ready low 5 cycles in RESP, r1 valid -> rsp_f/rsp0_valid stable, req1_ready=0,
//   busy=1; r1 accepted cycle after handshake.
//  ALU_LAT=4, r0 op=111 A=FFFFFFFF B=4 -> alu_* stable 4 EXEC cycles,
//   rsp_f=0FFFFFFF at T+5.
//  rst pulse during EXEC -> all outputs reset values, no rspN_valid, next grant goes to r0.

Source files
------------

// File: rtl/alu_rr_sequencer.sv
// Round-robin front end that shares one 32-bit combinational ALU between two requesters:
// arbitrates, registers operands onto the ALU, waits ALU_LAT cycles, captures result/flags, returns them.
module alu_rr_sequencer #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_f,
    output logic        rsp_zf,
    output logic        rsp_of,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_f,
    input  logic        alu_zf,
    input  logic        alu_of,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] f_q, f_d;
    logic        zf_q, zf_d, of_q, of_d;
    logic        winner;

    // last_q doubles as the grant of the transaction in flight, so RESP routes by it.
    always_comb begin
        winner     = (req0_valid & req1_valid) ? ~last_q : req1_valid;
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        f_d        = f_q;
        zf_d       = zf_q;
        of_d       = of_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    req0_ready = ~winner;
                    req1_ready = winner;
                    op_d       = winner ? req1_op : req0_op;
                    a_d        = winner ? req1_a  : req0_a;
                    b_d        = winner ? req1_b  : req0_b;
                    last_d     = winner;
                    cnt_d      = CNT_INIT;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    f_d     = alu_f;
                    zf_d    = alu_zf;
                    of_d    = alu_of;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                rsp0_valid = ~last_q;
                rsp1_valid = last_q;
                if (last_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            zf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            zf_q    <= zf_d;
            of_q    <= of_d;
        end
    end

    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign rsp_f  = f_q;
    assign rsp_zf = zf_q;
    assign rsp_of = of_q;
    assign busy   = (state_q != IDLE);

endmodule
